// File: rtl/box_overlay.sv
`default_nettype none
// =============================================================================
// box_overlay : draws up to 16 rectangular borders onto an RGB888 pixel stream
// Rev 1.0
// =============================================================================
module box_overlay #(
  parameter logic [9:0]  IMG_HDISP = 10'd640,
  parameter logic [9:0]  IMG_VDISP = 10'd480,
  parameter int          BOX_WIDTH = 2,
  parameter logic [23:0] BOX_COLOR = 24'hFF0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         per_frame_vsync,
  input  logic         per_frame_href,
  input  logic         per_frame_clken,
  input  logic [23:0]  per_img_data,
  input  logic [655:0] target_pos_in,
  input  logic         disp_sel,
  output logic         post_frame_vsync,
  output logic         post_frame_href,
  output logic         post_frame_clken,
  output logic [23:0]  post_img_data,
  output logic [4:0]   box_count
);

  localparam int         NBOX = 16;
  localparam logic [9:0] BW   = 10'(BOX_WIDTH);

  logic         vsync_q, vsync_d;
  logic [655:0] shadow_q, shadow_d;
  logic [4:0]   box_count_q, box_count_d;
  logic [9:0]   x_q, x_d, y_q, y_d;
  logic [15:0]  hit_q, hit_d;
  logic [23:0]  data1_q, data1_d;
  logic [2:0]   sync1_q, sync1_d;
  logic [2:0]   sync2_q, sync2_d;
  logic [23:0]  data2_q, data2_d;
  logic [15:0]  drawable;
  logic         load;

  assign load = per_frame_vsync & ~vsync_q;

  // The list is frozen at the frame start so boxes never tear mid-frame.
  always_comb begin
    vsync_d  = per_frame_vsync;
    shadow_d = load ? target_pos_in : shadow_q;
  end

  always_comb begin
    box_count_d = '0;
    for (int i = 0; i < NBOX; i++) begin
      box_count_d = box_count_d + {4'd0, drawable[i]};
    end
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (per_frame_vsync) begin
      x_d = '0;
      y_d = '0;
    end else if (per_frame_clken) begin
      if (x_q == IMG_HDISP - 10'd1) begin
        x_d = '0;
        if (y_q != IMG_VDISP - 10'd1) begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  // Range checks come first, so every difference below is non-negative when used.
  genvar k;
  generate
    for (k = 0; k < NBOX; k++) begin : g_box
      logic [40:0] box;
      logic [9:0]  left, top, right, bottom;
      logic        in_x, in_y, near;
      assign box    = shadow_q[41*k +: 41];
      assign left   = box[9:0];
      assign top    = box[19:10];
      assign right  = box[29:20];
      assign bottom = box[39:30];
      assign drawable[k] = box[40] & (left <= right) & (top <= bottom);
      assign in_x = (x_q >= left) & (x_q <= right);
      assign in_y = (y_q >= top) & (y_q <= bottom);
      assign near = ((x_q - left) < BW) | ((right - x_q) < BW) |
                    ((y_q - top) < BW) | ((bottom - y_q) < BW);
      assign hit_d[k] = drawable[k] & in_x & in_y & near;
    end
  endgenerate

  always_comb begin
    data1_d = per_img_data;
    sync1_d = {per_frame_vsync, per_frame_href, per_frame_clken};
    sync2_d = sync1_q;
    if (!sync1_q[0]) begin
      data2_d = 24'd0;
    end else if ((|hit_q) && disp_sel) begin
      data2_d = BOX_COLOR;
    end else begin
      data2_d = data1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q     <= 1'b0;
      shadow_q    <= '0;
      box_count_q <= '0;
      x_q         <= '0;
      y_q         <= '0;
      hit_q       <= '0;
      data1_q     <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      data2_q     <= '0;
    end else begin
      vsync_q     <= vsync_d;
      shadow_q    <= shadow_d;
      box_count_q <= box_count_d;
      x_q         <= x_d;
      y_q         <= y_d;
      hit_q       <= hit_d;
      data1_q     <= data1_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      data2_q     <= data2_d;
    end
  end

  assign post_frame_vsync = sync2_q[2];
  assign post_frame_href  = sync2_q[1];
  assign post_frame_clken = sync2_q[0];
  assign post_img_data    = data2_q;
  assign box_count        = box_count_q;

endmodule
`default_nettype wire

// File: tb/tb_box_overlay.sv
`default_nettype none
// =============================================================================
// tb_box_overlay : directed self-checking bench for box_overlay (16x8 image)
// Rev 1.0
// =============================================================================
module tb_box_overlay;

  localparam logic [23:0] COLOR = 24'hFF0000;
  localparam int HD = 16;
  localparam int VD = 8;

  logic         clk;
  logic         rst_n;
  logic         vs, hr, ce;
  logic [23:0]  din;
  logic [655:0] tpos;
  logic         disp_sel;

  logic         pv1, ph1, pc1;
  logic [23:0]  pd1;
  logic [4:0]   bc1;
  logic         pv2, ph2, pc2;
  logic [23:0]  pd2;
  logic [4:0]   bc2;

  box_overlay #(.IMG_HDISP(10'd16), .IMG_VDISP(10'd8), .BOX_WIDTH(1), .BOX_COLOR(COLOR)) dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ce),
    .per_img_data(din), .target_pos_in(tpos), .disp_sel(disp_sel),
    .post_frame_vsync(pv1), .post_frame_href(ph1), .post_frame_clken(pc1),
    .post_img_data(pd1), .box_count(bc1)
  );

  box_overlay #(.IMG_HDISP(10'd16), .IMG_VDISP(10'd8), .BOX_WIDTH(2), .BOX_COLOR(COLOR)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ce),
    .per_img_data(din), .target_pos_in(tpos), .disp_sel(disp_sel),
    .post_frame_vsync(pv2), .post_frame_href(ph2), .post_frame_clken(pc2),
    .post_img_data(pd2), .box_count(bc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt1, cnt2, fno;
  logic [655:0] act, list1, list2;
  logic [2:0]   es_d1, es_d2;
  logic [23:0]  e1_d1, e1_d2, e2_d1, e2_d2;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [40:0] mkbox(input logic v, input int b, input int r, input int t, input int l);
    return {v, 10'(b), 10'(r), 10'(t), 10'(l)};
  endfunction

  function automatic logic [23:0] pix(input int x, input int y, input int f);
    return {8'(x * 11 + f * 3), 8'(y * 29 + 1), 8'h5A};
  endfunction

  // Geometric reference: inside the rectangle and within bw of any edge.
  function automatic logic [23:0] exp_px(input int x, input int y, input logic [23:0] d,
                                         input logic disp, input int bw);
    logic [40:0]  bx;
    logic [23:0]  res;
    int l, t, r, b;
    res = d;
    if (disp) begin
      for (int k = 0; k < 16; k++) begin
        bx = act[41*k +: 41];
        l = {22'd0, bx[9:0]};
        t = {22'd0, bx[19:10]};
        r = {22'd0, bx[29:20]};
        b = {22'd0, bx[39:30]};
        if (bx[40] && l <= r && t <= b && x >= l && x <= r && y >= t && y <= b &&
            ((x - l) < bw || (r - x) < bw || (y - t) < bw || (b - y) < bw))
          res = COLOR;
      end
    end
    return res;
  endfunction

  // Checks the outputs produced by the inputs of two calls ago, then drives new inputs.
  task automatic step(input logic v, input logic h, input logic c, input logic [23:0] d,
                      input logic [23:0] x1, input logic [23:0] x2);
    @(posedge clk);
    #1;
    check_eq("sync", {29'd0, pv1, ph1, pc1}, {29'd0, es_d2});
    check_eq("data_bw1", {8'd0, pd1}, {8'd0, e1_d2});
    check_eq("data_bw2", {8'd0, pd2}, {8'd0, e2_d2});
    if (pc1 && pd1 == COLOR) cnt1++;
    if (pc2 && pd2 == COLOR) cnt2++;
    es_d2 = es_d1; e1_d2 = e1_d1; e2_d2 = e2_d1;
    es_d1 = {v, h, c}; e1_d1 = x1; e2_d1 = x2;
    vs = v; hr = h; ce = c; din = d;
  endtask

  task automatic frame(input logic disp, input int rst_at, input int chg_at,
                       input logic [655:0] new_tpos, input int bc_start, input int bc_end,
                       input int c1, input int c2);
    logic [23:0] d;
    int p;
    disp_sel = disp;
    cnt1 = 0;
    cnt2 = 0;
    fno++;
    act = tpos;
    repeat (3) step(1'b1, 1'b0, 1'b0, 24'd0, 24'd0, 24'd0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 24'd0, 24'd0, 24'd0);
    check_eq("box_count_start", {27'd0, bc1}, bc_start);
    check_eq("box_count_start_bw2", {27'd0, bc2}, bc_start);
    p = 0;
    for (int y = 0; y < VD; y++) begin
      for (int x = 0; x < HD; x++) begin
        if (p == chg_at) tpos = new_tpos;
        if (p == rst_at) begin
          #2 rst_n = 1'b0;
          #1;
          check_eq("rst_data", {8'd0, pd1}, 32'd0);
          check_eq("rst_sync", {29'd0, pv1, ph1, pc1}, 32'd0);
          check_eq("rst_box_count", {27'd0, bc1}, 32'd0);
          act = '0;
          es_d2 = '0; e1_d2 = '0; e2_d2 = '0;
          #3 rst_n = 1'b1;
        end
        d = pix(x, y, fno);
        step(1'b0, 1'b1, 1'b1, d, exp_px(x, y, d, disp, 1), exp_px(x, y, d, disp, 2));
        p++;
      end
      repeat (2) step(1'b0, 1'b0, 1'b0, 24'd0, 24'd0, 24'd0);
    end
    check_eq("box_count_end", {27'd0, bc1}, bc_end);
    check_eq("colored_bw1", cnt1, c1);
    check_eq("colored_bw2", cnt2, c2);
  endtask

  initial begin
    rst_n = 1'b0;
    vs = 1'b0; hr = 1'b0; ce = 1'b0; din = '0;
    disp_sel = 1'b0;
    fno = 0;
    es_d1 = '0; es_d2 = '0; e1_d1 = '0; e1_d2 = '0; e2_d1 = '0; e2_d2 = '0;

    list1 = '0;
    list1[0*41 +: 41] = mkbox(1'b1, 5, 10, 2, 3);
    list1[1*41 +: 41] = mkbox(1'b1, 6, 4, 1, 9);
    list1[2*41 +: 41] = mkbox(1'b0, 7, 15, 0, 0);
    list2 = '0;
    list2[0*41 +: 41]  = mkbox(1'b1, 3, 4, 2, 3);
    list2[5*41 +: 41]  = mkbox(1'b1, 3, 4, 2, 3);
    list2[15*41 +: 41] = mkbox(1'b1, 7, 15, 7, 15);
    tpos = list1;
    act  = '0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_data", {8'd0, pd1}, 32'd0);
    check_eq("reset_data_bw2", {8'd0, pd2}, 32'd0);
    check_eq("reset_sync", {29'd0, pv1, ph1, pc1}, 32'd0);
    check_eq("reset_box_count", {27'd0, bc1}, 32'd0);
    rst_n = 1'b1;

    // border frame, bypass frame, mid-frame list change, new list, reset, reload
    frame(1'b1, -1, -1, list1, 1, 1, 20, 32);
    frame(1'b0, -1, -1, list1, 1, 1, 0, 0);
    frame(1'b1, -1, 60, list2, 1, 1, 20, 32);
    frame(1'b1, -1, -1, list2, 3, 3, 5, 5);
    frame(1'b1, 40, -1, list2, 3, 0, 2, 2);
    frame(1'b1, -1, -1, list2, 3, 3, 5, 5);

    repeat (3) step(1'b0, 1'b0, 1'b0, 24'd0, 24'd0, 24'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
